// File: rtl/am_sequencer_pkg.sv
// Shared types, widths and FSM encoding for the all_moves sequencer.
package am_sequencer_pkg;

    localparam int unsigned MAX_POSITIONS_LOG2 = 8;
    localparam int unsigned EVAL_WIDTH         = 24;
    localparam int unsigned UCI_WIDTH          = 16;
    localparam int unsigned AM_SEQ_TIMEOUT     = 4096;

    typedef logic        [MAX_POSITIONS_LOG2-1:0] move_idx_t;
    typedef logic signed [EVAL_WIDTH-1:0]         eval_t;
    typedef logic        [UCI_WIDTH-1:0]          uci_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_MOVES,
        ST_SET_INDEX,
        ST_WAIT_RAM,
        ST_SAMPLE,
        ST_CLEAR,
        ST_WAIT_IDLE,
        ST_DONE
    } am_state_e;

    // Best-move record kept while walking the move RAM.
    typedef struct packed {
        move_idx_t index;
        uci_t      uci;
        eval_t     eval;
    } best_move_t;

endpackage

// File: rtl/am_sequencer_if.sv
// Control and result signals between the host front end, all_moves and the sequencer.
interface am_sequencer_if;
    import am_sequencer_pkg::*;

    logic      req_valid;
    logic      req_ready;
    logic      req_white_to_move;
    logic      am_board_valid;
    logic      am_moves_ready;
    logic      am_idle;
    move_idx_t am_move_count;
    move_idx_t am_move_index;
    logic      am_clear_moves;
    eval_t     eval_in;
    uci_t      uci_in;
    logic      initial_mate;
    logic      initial_stalemate;
    logic      done;
    move_idx_t best_index;
    uci_t      best_uci;
    eval_t     best_eval;
    move_idx_t move_count;
    logic      mate;
    logic      stalemate;
    logic      timeout;

    modport master (
        input  req_valid, req_white_to_move, am_moves_ready, am_idle, am_move_count,
               eval_in, uci_in, initial_mate, initial_stalemate,
        output req_ready, am_board_valid, am_move_index, am_clear_moves, done,
               best_index, best_uci, best_eval, move_count, mate, stalemate, timeout
    );

    modport slave (
        output req_valid, req_white_to_move, am_moves_ready, am_idle, am_move_count,
               eval_in, uci_in, initial_mate, initial_stalemate,
        input  req_ready, am_board_valid, am_move_index, am_clear_moves, done,
               best_index, best_uci, best_eval, move_count, mate, stalemate, timeout
    );

endinterface

// File: rtl/am_sequencer_eval_compare.sv
// Signed "candidate strictly better than best" test; white maximises, black minimises.
module am_sequencer_eval_compare
    import am_sequencer_pkg::*;
(
    input  eval_t cand_eval_i,
    input  eval_t best_eval_i,
    input  logic  white_i,
    output logic  better_c_o
);

    assign better_c_o = white_i ? (cand_eval_i > best_eval_i) : (cand_eval_i < best_eval_i);

endmodule

// File: rtl/am_sequencer.sv
// Sequences one all_moves generation pass per request and reports the best move.
module am_sequencer
    import am_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = AM_SEQ_TIMEOUT
)
(
    input  logic           clk,
    input  logic           reset,
    am_sequencer_if.master bus
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned IDX_W   = MAX_POSITIONS_LOG2;
    localparam int unsigned NEXT_W  = IDX_W + 1;

    am_state_e          state_q;
    logic               white_q;
    logic               req_ready_q;
    logic               board_valid_q;
    logic               clear_q;
    logic               done_q;
    logic               mate_q;
    logic               stalemate_q;
    logic               timeout_q;
    move_idx_t          index_q;
    move_idx_t          count_q;
    best_move_t         best_q;
    logic [TIMER_W-1:0] timer_q;

    logic [NEXT_W-1:0]  next_index_d;
    logic               last_move_c;
    logic               better_c;
    logic               timer_expired_c;

    // One extra bit so a full 2^W-1 move list ends without the index wrapping.
    assign next_index_d    = {1'b0, index_q} + NEXT_W'(1);
    assign last_move_c     = next_index_d >= {1'b0, count_q};
    assign timer_expired_c = timer_q == TIMER_W'(TIMEOUT_CYCLES - 1);

    am_sequencer_eval_compare u_eval_compare (
        .cand_eval_i (bus.eval_in),
        .best_eval_i (best_q.eval),
        .white_i     (white_q),
        .better_c_o  (better_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            white_q       <= 1'b0;
            req_ready_q   <= 1'b1;
            board_valid_q <= 1'b0;
            clear_q       <= 1'b0;
            done_q        <= 1'b0;
            mate_q        <= 1'b0;
            stalemate_q   <= 1'b0;
            timeout_q     <= 1'b0;
            index_q       <= '0;
            count_q       <= '0;
            best_q        <= '0;
            timer_q       <= '0;
        end else begin
            board_valid_q <= 1'b0;
            clear_q       <= 1'b0;
            done_q        <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        white_q       <= bus.req_white_to_move;
                        req_ready_q   <= 1'b0;
                        board_valid_q <= 1'b1;
                        mate_q        <= 1'b0;
                        stalemate_q   <= 1'b0;
                        timeout_q     <= 1'b0;
                        count_q       <= '0;
                        best_q        <= '0;
                        state_q       <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    timer_q <= '0;
                    state_q <= ST_WAIT_MOVES;
                end
                ST_WAIT_MOVES: begin
                    if (bus.am_moves_ready) begin
                        count_q <= bus.am_move_count;
                        if (bus.am_move_count == '0) begin
                            mate_q      <= bus.initial_mate;
                            stalemate_q <= bus.initial_stalemate;
                            best_q      <= '0;
                            clear_q     <= 1'b1;
                            state_q     <= ST_CLEAR;
                        end else begin
                            index_q <= '0;
                            state_q <= ST_SET_INDEX;
                        end
                    end else if (timer_expired_c) begin
                        timeout_q <= 1'b1;
                        clear_q   <= 1'b1;
                        state_q   <= ST_CLEAR;
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end
                ST_SET_INDEX: state_q <= ST_WAIT_RAM;
                ST_WAIT_RAM:  state_q <= ST_SAMPLE;
                ST_SAMPLE: begin
                    // Strict compare: on a tie the earlier (lower) index is kept.
                    if (index_q == '0 || better_c) begin
                        best_q.index <= index_q;
                        best_q.uci   <= bus.uci_in;
                        best_q.eval  <= bus.eval_in;
                    end
                    if (last_move_c) begin
                        clear_q <= 1'b1;
                        state_q <= ST_CLEAR;
                    end else begin
                        index_q <= IDX_W'(next_index_d);
                        state_q <= ST_SET_INDEX;
                    end
                end
                ST_CLEAR: begin
                    timer_q <= '0;
                    state_q <= ST_WAIT_IDLE;
                end
                ST_WAIT_IDLE: begin
                    if (bus.am_idle) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (timer_expired_c) begin
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end
                ST_DONE: begin
                    index_q     <= '0;
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready      = req_ready_q;
    assign bus.am_board_valid = board_valid_q;
    assign bus.am_move_index  = index_q;
    assign bus.am_clear_moves = clear_q;
    assign bus.done           = done_q;
    assign bus.best_index     = best_q.index;
    assign bus.best_uci       = best_q.uci;
    assign bus.best_eval      = best_q.eval;
    assign bus.move_count     = count_q;
    assign bus.mate           = mate_q;
    assign bus.stalemate      = stalemate_q;
    assign bus.timeout        = timeout_q;

endmodule

// File: tb/tb_am_sequencer.sv
// Directed bench for am_sequencer with a 2-cycle-latency move RAM stub.
module tb_am_sequencer;
    import am_sequencer_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    am_sequencer_if bus ();

    am_sequencer #(.TIMEOUT_CYCLES(4096)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Move RAM stub: data appears two clocks after the address.
    eval_t mem_eval [256];
    uci_t  mem_uci  [256];
    eval_t ram_e1;
    uci_t  ram_u1;
    always @(posedge clk) begin
        ram_e1      <= mem_eval[bus.am_move_index];
        ram_u1      <= mem_uci[bus.am_move_index];
        bus.eval_in <= ram_e1;
        bus.uci_in  <= ram_u1;
    end

    // Event monitor, sampled on the falling edge.
    int        cyc = 0, bv_cnt = 0, bv_cyc = 0, clr_cnt = 0, clr_cyc = 0;
    int        done_cnt = 0, done_cyc = 0, req_cyc = 0, rdy_cyc = 0;
    int        chg_cyc = 0, period_err = 0;
    move_idx_t prev_idx = '0;
    logic      prev_rdy = 1'b0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.req_valid && bus.req_ready) req_cyc <= cyc;
        if (bus.am_moves_ready && !prev_rdy) rdy_cyc <= cyc;
        prev_rdy <= bus.am_moves_ready;
        if (bus.am_clear_moves) begin clr_cnt <= clr_cnt + 1; clr_cyc <= cyc; end
        if (bus.done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
        if (bus.am_move_index != prev_idx) begin
            if (chg_cyc != 0 && bus.am_move_index != '0 && cyc - chg_cyc != 3)
                period_err <= period_err + 1;
            chg_cyc  <= cyc;
            prev_idx <= bus.am_move_index;
        end
        if (bus.am_board_valid) begin bv_cnt <= bv_cnt + 1; bv_cyc <= cyc; chg_cyc <= 0; end
    end

    int s_clr, s_done, s_bv;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_linear();
        for (int i = 0; i < 256; i++) begin
            mem_eval[i] = EVAL_WIDTH'(i);
            mem_uci[i]  = UCI_WIDTH'(32'h1000 + i);
        end
    endtask

    task automatic start_req(input logic white, input int count);
        s_clr  = clr_cnt;
        s_done = done_cnt;
        s_bv   = bv_cnt;
        bus.am_move_count = MAX_POSITIONS_LOG2'(count);
        tick();
        bus.req_valid         = 1'b1;
        bus.req_white_to_move = white;
        bus.am_idle           = 1'b0;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic give_moves(input int delay);
        repeat (delay) tick();
        bus.am_moves_ready = 1'b1;
    endtask

    task automatic finish_req(input string tag, input int idle_delay, input int budget);
        int n;
        n = 0;
        while (clr_cnt == s_clr && n < budget) begin tick(); n++; end
        chk({tag, "_clear_seen"}, 32'(clr_cnt != s_clr), 1);
        bus.am_moves_ready = 1'b0;
        repeat (idle_delay) tick();
        bus.am_idle = 1'b1;
        n = 0;
        while (done_cnt == s_done && n < 50) begin tick(); n++; end
        chk({tag, "_done_seen"}, 32'(done_cnt != s_done), 1);
        tick();
        chk({tag, "_one_bv"}, 32'(bv_cnt - s_bv), 1);
        chk({tag, "_bv_latency"}, 32'(bv_cyc - req_cyc), 1);
        chk({tag, "_one_clear"}, 32'(clr_cnt - s_clr), 1);
        chk({tag, "_one_done"}, 32'(done_cnt - s_done), 1);
        chk({tag, "_done_after_clear"}, 32'(done_cyc - clr_cyc), 32'(2 + idle_delay));
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 1);
        chk({tag, "_index_idle"}, 32'(bus.am_move_index), 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 1);
        chk({tag, "_board_valid"}, 32'(bus.am_board_valid), 0);
        chk({tag, "_index"}, 32'(bus.am_move_index), 0);
        chk({tag, "_clear"}, 32'(bus.am_clear_moves), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_best_index"}, 32'(bus.best_index), 0);
        chk({tag, "_best_uci"}, 32'(bus.best_uci), 0);
        chk({tag, "_best_eval"}, 32'(bus.best_eval), 0);
        chk({tag, "_move_count"}, 32'(bus.move_count), 0);
        chk({tag, "_flags"}, 32'({bus.mate, bus.stalemate, bus.timeout}), 0);
    endtask

    initial begin
        int n;
        bus.req_valid         = 1'b0;
        bus.req_white_to_move = 1'b0;
        bus.am_moves_ready    = 1'b0;
        bus.am_idle           = 1'b1;
        bus.am_move_count     = '0;
        bus.initial_mate      = 1'b0;
        bus.initial_stalemate = 1'b0;
        fill_linear();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk_reset("por");

        // White, 20 moves with eval == index.
        start_req(1'b1, 20);
        give_moves(1);
        finish_req("w20", 0, 200);
        chk("w20_best_index", 32'(bus.best_index), 19);
        chk("w20_best_eval", 32'(bus.best_eval), 19);
        chk("w20_best_uci", 32'(bus.best_uci), 32'h1013);
        chk("w20_move_count", 32'(bus.move_count), 20);
        chk("w20_clear_timing", 32'(clr_cyc - rdy_cyc), 61);
        chk("w20_period", 32'(period_err), 0);

        // No legal moves, checkmate.
        bus.initial_mate = 1'b1;
        start_req(1'b1, 0);
        give_moves(1);
        finish_req("mate", 0, 50);
        chk("mate_flag", 32'(bus.mate), 1);
        chk("mate_stalemate", 32'(bus.stalemate), 0);
        chk("mate_best_index", 32'(bus.best_index), 0);
        chk("mate_best_eval", 32'(bus.best_eval), 0);
        chk("mate_clear_timing", 32'(clr_cyc - rdy_cyc), 1);
        bus.initial_mate = 1'b0;

        // Generator never reports ready.
        start_req(1'b0, 7);
        finish_req("tmo", 0, 5000);
        chk("tmo_flag", 32'(bus.timeout), 1);
        chk("tmo_mate_cleared", 32'(bus.mate), 0);
        chk("tmo_move_count", 32'(bus.move_count), 0);
        chk("tmo_clear_timing", 32'(clr_cyc - bv_cyc), 4097);

        // No legal moves, stalemate.
        bus.initial_stalemate = 1'b1;
        start_req(1'b0, 0);
        give_moves(1);
        finish_req("stale", 0, 50);
        chk("stale_flag", 32'(bus.stalemate), 1);
        chk("stale_mate", 32'(bus.mate), 0);
        chk("stale_timeout_cleared", 32'(bus.timeout), 0);
        bus.initial_stalemate = 1'b0;

        // White, mixed signs with a tie; a stray request mid-pass is ignored.
        mem_eval[0] = EVAL_WIDTH'(-10);
        mem_eval[1] = EVAL_WIDTH'(4);
        mem_eval[2] = EVAL_WIDTH'(-2);
        mem_eval[3] = EVAL_WIDTH'(4);
        mem_eval[4] = EVAL_WIDTH'(3);
        start_req(1'b1, 5);
        tick();
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        give_moves(1);
        finish_req("mix", 0, 100);
        chk("mix_best_index", 32'(bus.best_index), 1);
        chk("mix_best_eval", 32'(bus.best_eval), 4);
        chk("mix_best_uci", 32'(bus.best_uci), 32'h1001);
        chk("mix_clear_timing", 32'(clr_cyc - rdy_cyc), 16);

        // Reset during SAMPLE of move 5.
        fill_linear();
        start_req(1'b1, 10);
        give_moves(1);
        n = 0;
        while (bus.am_move_index != MAX_POSITIONS_LOG2'(5) && n < 100) begin tick(); n++; end
        chk("rst_reach_index5", 32'(bus.am_move_index), 5);
        repeat (2) tick();
        reset = 1'b1;
        #1;
        chk_reset("midrst");
        tick();
        reset              = 1'b0;
        bus.am_moves_ready = 1'b0;
        bus.am_idle        = 1'b1;
        repeat (3) tick();
        chk("midrst_no_clear", 32'(clr_cnt - s_clr), 0);
        chk("midrst_no_done", 32'(done_cnt - s_done), 0);

        // Black after reset, {5,-3,-3,7}, generator slow to go idle.
        mem_eval[0] = EVAL_WIDTH'(5);
        mem_eval[1] = EVAL_WIDTH'(-3);
        mem_eval[2] = EVAL_WIDTH'(-3);
        mem_eval[3] = EVAL_WIDTH'(7);
        start_req(1'b0, 4);
        give_moves(2);
        finish_req("blk", 5, 100);
        chk("blk_best_index", 32'(bus.best_index), 1);
        chk("blk_best_eval", 32'(bus.best_eval), -3);
        chk("blk_best_uci", 32'(bus.best_uci), 32'h1001);
        chk("blk_move_count", 32'(bus.move_count), 4);
        chk("blk_clear_timing", 32'(clr_cyc - rdy_cyc), 13);

        // Full-size move list: index must not wrap.
        fill_linear();
        mem_eval[254] = EVAL_WIDTH'(1000);
        start_req(1'b1, 255);
        give_moves(1);
        finish_req("max", 0, 1000);
        chk("max_best_index", 32'(bus.best_index), 254);
        chk("max_best_eval", 32'(bus.best_eval), 1000);
        chk("max_move_count", 32'(bus.move_count), 255);
        chk("max_clear_timing", 32'(clr_cyc - rdy_cyc), 766);
        chk("all_period", 32'(period_err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
